rand_vec_checker: RTL
=====================

RAND_VEC_CHECKER -- requirements
Module: rand_vec_checker

Interface
REQ-001 Parameter IN_W, default 2: stimulus width, SHALL be 1..32.
REQ-002 Parameter OUT_W, default 1: compared output width, SHALL be at least 1.
REQ-003 Parameter NUM_VEC, default 16: compared vectors per run, SHALL be at least 1.
REQ-004 Parameter SKIP, default 1: initialization cycles excluded from comparison, SHALL be at least 0.
REQ-005 Parameter SEED, default 32'hACE1_2B35: LFSR seed, SHALL be nonzero.
REQ-006 Parameter ERR_W, default 16: error counter width.
REQ-007 clk  input  1  single clock; all state rising-edge.
REQ-008 rst_n  input  1  asynchronous, active-low reset.
REQ-009 start  input  1  begin a run; sampled in IDLE or DONE only.
REQ-010 stim_o  output  IN_W  registered stimulus shared by DUT and reference.
REQ-011 dut_out_i  input  OUT_W  fabric (DUT) output, combinational from stim_o.
REQ-012 ref_out_i  input  OUT_W  benchmark output, combinational from stim_o.
REQ-013 ref_x_i  input  OUT_W  per-bit don't-care mask; 1 = bit excluded (reference X).
REQ-014 busy  output  1  high in WARMUP or RUN.
REQ-015 done  output  1  high in DONE.
REQ-016 pass  output  1  high in DONE when err_cnt == 0.
REQ-017 err_cnt  output  ERR_W  count of mismatching vectors, saturating.
REQ-018 first_err_idx  output  clog2(NUM_VEC+1)  vector index of first mismatch.
REQ-019 first_err_mask  output  OUT_W  mismatching bits of the first mismatch.

Function
REQ-020 FSM states SHALL be IDLE, WARMUP, RUN, DONE.
REQ-021 IDLE with start=1 at an edge: LFSR <= SEED, skip and vector counters <= 0, err_cnt, first_err_* cleared; next state WARMUP if SKIP>0, else RUN.
REQ-022 stim_o SHALL equal LFSR[IN_W-1:0]; the first stimulus after start SHALL be SEED[IN_W-1:0].
REQ-023 LFSR SHALL be 32-bit Galois, polynomial x^32+x^22+x^2+x+1, advancing once per clock in WARMUP and RUN only; held otherwise.
REQ-024 WARMUP SHALL last exactly SKIP cycles with no comparison, then go to RUN.
REQ-025 Each RUN cycle: mismatch = (dut_out_i ^ ref_out_i) & ~ref_x_i; a nonzero mismatch increments err_cnt at that edge.
REQ-026 err_cnt SHALL saturate at 2^ERR_W-1.
REQ-027 On the first mismatch of a run, first_err_idx SHALL capture the vector counter value and first_err_mask the mismatch bits; later mismatches do not change them.
REQ-028 Vector counter SHALL increment per RUN cycle; the edge completing vector NUM_VEC-1 SHALL enter DONE, giving exactly NUM_VEC compares.
REQ-029 start SHALL be ignored in WARMUP and RUN; start in DONE SHALL restart as in REQ-021.
REQ-030 DONE SHALL hold all results until restart or reset; pass = done && err_cnt == 0.

Reset
REQ-031 rst_n low SHALL asynchronously force IDLE, LFSR=SEED, stim_o=SEED[IN_W-1:0], busy=done=pass=0, err_cnt=0, first_err_idx=0, first_err_mask=0.
REQ-032 Reset asserted mid-run SHALL discard the run; no partial result remains visible.

Structure
REQ-033 Package rand_vec_checker_pkg SHALL hold the FSM state enum and the LFSR polynomial constant.
REQ-034 The LFSR SHALL be one sub-module, lfsr32_galois (load, enable, seed in, state out).

Verification
REQ-035 dut_out_i tied to ref_out_i, defaults: start pulse -> done after 1+SKIP+NUM_VEC=18 cycles, pass=1, err_cnt=0.
REQ-036 dut_out_i = ~ref_out_i: err_cnt=16, first_err_idx=0, first_err_mask=1, pass=0.
REQ-037 One mismatch injected on vector 5 only -> err_cnt=1, first_err_idx=5, first_err_mask=1.
REQ-038 Mismatch on every vector with ref_x_i=1; separately, mismatch only in WARMUP -> err_cnt=0, pass=1 in both runs.
REQ-039 ERR_W=3, all vectors mismatching -> err_cnt=7 (saturated); stim_o sequence matches a golden Galois LFSR model from SEED.
REQ-040 rst_n low at RUN vector 8 -> immediate IDLE, all outputs at reset values; a new start then yields a full 16-vector run.

Source files
------------

// File: rtl/rand_vec_checker_pkg.sv
// Shared types and constants for the random-vector equivalence checker.
// Holds the checker FSM encoding and the Galois LFSR feedback polynomial.
package rand_vec_checker_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WARMUP = 2'd1,
        ST_RUN    = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    // Right-shifting Galois form of x^32 + x^22 + x^2 + x + 1.
    localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? LFSR_POLY : 32'h0000_0000);
    endfunction

endpackage

// File: rtl/rand_vec_checker_lfsr.sv
// 32-bit Galois LFSR with synchronous load and enable; exposes only the
// low OUT_W bits so callers needing fewer bits leave nothing dangling.
module lfsr32_galois
    import rand_vec_checker_pkg::*;
#(
    parameter logic [31:0] SEED  = 32'hACE1_2B35,
    parameter int          OUT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             enable,
    input  logic [31:0]      seed_i,
    output logic [OUT_W-1:0] state_o
);

    logic [31:0] state_q;
    logic [31:0] state_d;

    // NOTE: combinational blocks assign a default first so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        if (load) begin
            state_d = seed_i;
        end else if (enable) begin
            state_d = lfsr_step(state_q);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SEED;
        end else begin
            state_q <= state_d;
        end
    end

    assign state_o = state_q[OUT_W-1:0];

endmodule

// File: rtl/rand_vec_checker.sv
// Drives pseudo-random stimulus to a DUT and a reference in lockstep and
// counts masked output mismatches over a fixed number of vectors.
module rand_vec_checker
    import rand_vec_checker_pkg::*;
#(
    parameter int          IN_W    = 2,
    parameter int          OUT_W   = 1,
    parameter int          NUM_VEC = 16,
    parameter int          SKIP    = 1,
    parameter logic [31:0] SEED    = 32'hACE1_2B35,
    parameter int          ERR_W   = 16,
    localparam int         IDX_W   = $clog2(NUM_VEC + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic [IN_W-1:0]  stim_o,
    input  logic [OUT_W-1:0] dut_out_i,
    input  logic [OUT_W-1:0] ref_out_i,
    input  logic [OUT_W-1:0] ref_x_i,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_cnt,
    output logic [IDX_W-1:0] first_err_idx,
    output logic [OUT_W-1:0] first_err_mask
);

    localparam int               SKIP_W    = (SKIP > 0) ? $clog2(SKIP + 1) : 1;
    localparam logic [SKIP_W-1:0] SKIP_LAST = SKIP_W'((SKIP > 0) ? SKIP - 1 : 0);
    localparam logic [IDX_W-1:0]  VEC_LAST  = IDX_W'(NUM_VEC - 1);
    localparam logic [ERR_W-1:0]  ERR_MAX   = {ERR_W{1'b1}};

    state_e            state_q, state_d;
    logic [SKIP_W-1:0] skip_cnt_q, skip_cnt_d;
    logic [IDX_W-1:0]  vec_cnt_q, vec_cnt_d;
    logic [ERR_W-1:0]  err_cnt_q, err_cnt_d;
    logic [IDX_W-1:0]  first_idx_q, first_idx_d;
    logic [OUT_W-1:0]  first_mask_q, first_mask_d;
    logic [OUT_W-1:0]  mismatch;
    logic              lfsr_load;
    logic              lfsr_en;

    lfsr32_galois #(
        .SEED  (SEED),
        .OUT_W (IN_W)
    ) u_lfsr (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (lfsr_load),
        .enable  (lfsr_en),
        .seed_i  (SEED),
        .state_o (stim_o)
    );

    assign mismatch = (dut_out_i ^ ref_out_i) & ~ref_x_i;

    always_comb begin
        state_d      = state_q;
        skip_cnt_d   = skip_cnt_q;
        vec_cnt_d    = vec_cnt_q;
        err_cnt_d    = err_cnt_q;
        first_idx_d  = first_idx_q;
        first_mask_d = first_mask_q;
        lfsr_load    = 1'b0;
        lfsr_en      = 1'b0;

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    lfsr_load    = 1'b1;
                    skip_cnt_d   = '0;
                    vec_cnt_d    = '0;
                    err_cnt_d    = '0;
                    first_idx_d  = '0;
                    first_mask_d = '0;
                    state_d      = (SKIP > 0) ? ST_WARMUP : ST_RUN;
                end
            end

            ST_WARMUP: begin
                lfsr_en    = 1'b1;
                skip_cnt_d = skip_cnt_q + SKIP_W'(1);
                if (skip_cnt_q == SKIP_LAST) begin
                    state_d = ST_RUN;
                end
            end

            ST_RUN: begin
                lfsr_en   = 1'b1;
                vec_cnt_d = vec_cnt_q + IDX_W'(1);
                if (mismatch != '0) begin
                    // A saturating counter never returns to zero, so zero
                    // means this is the first mismatch of the run.
                    if (err_cnt_q == '0) begin
                        first_idx_d  = vec_cnt_q;
                        first_mask_d = mismatch;
                    end
                    if (err_cnt_q != ERR_MAX) begin
                        err_cnt_d = err_cnt_q + ERR_W'(1);
                    end
                end
                if (vec_cnt_q == VEC_LAST) begin
                    state_d = ST_DONE;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            skip_cnt_q   <= '0;
            vec_cnt_q    <= '0;
            err_cnt_q    <= '0;
            first_idx_q  <= '0;
            first_mask_q <= '0;
        end else begin
            state_q      <= state_d;
            skip_cnt_q   <= skip_cnt_d;
            vec_cnt_q    <= vec_cnt_d;
            err_cnt_q    <= err_cnt_d;
            first_idx_q  <= first_idx_d;
            first_mask_q <= first_mask_d;
        end
    end

    assign busy           = (state_q == ST_WARMUP) || (state_q == ST_RUN);
    assign done           = (state_q == ST_DONE);
    assign pass           = done && (err_cnt_q == '0);
    assign err_cnt        = err_cnt_q;
    assign first_err_idx  = first_idx_q;
    assign first_err_mask = first_mask_q;

endmodule
